varredura_teclado: RTL

- 4x4 matrix keypad scanner and debouncer. It drives the columns, samples the rows, debounces, and encodes the key.
- It is the producing end of the keypad interface consumed by the lock control unit. It emits a single-cycle `tecla_ativada` pulse with a stable 4-bit `digito` for each debounced press.
- It sits between the keypad pins and the control unit and memory write path.

---
 rtl/varredura_teclado.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/varredura_teclado.sv
// 4x4 keypad scanner/debouncer: drives one column low, samples rows, emits one pulse per debounced press.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module varredura_teclado #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] linhas,
    output logic [3:0] colunas,
    output logic       tecla_ativada,
    output logic [3:0] digito
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    // Fires one cycle early: the extra PRESSED cycle completes the REPEAT_CYCLES period.
    localparam logic [REP_W-1:0] REP_FIRE = REP_W'(REPEAT_CYCLES - 2);
    logic [REP_W-1:0] rep_cnt;
`endif

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, HELD} state_t;

    state_t           state;
    logic [3:0]       sync1;
    logic [3:0]       ls;
    logic [1:0]       col;
    logic [1:0]       row;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] rel_cnt;

    logic             single_low;
    logic [1:0]       low_row;
    logic [3:0]       row_pat;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        col_drive = ~(4'b0001 << c);
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'd1;
            4'h1: key_code = 4'd2;
            4'h2: key_code = 4'd3;
            4'h3: key_code = 4'd10;
            4'h4: key_code = 4'd4;
            4'h5: key_code = 4'd5;
            4'h6: key_code = 4'd6;
            4'h7: key_code = 4'd11;
            4'h8: key_code = 4'd7;
            4'h9: key_code = 4'd8;
            4'hA: key_code = 4'd9;
            4'hB: key_code = 4'd12;
            4'hC: key_code = 4'd14;
            4'hD: key_code = 4'd0;
            4'hE: key_code = 4'd15;
            default: key_code = 4'd13;
        endcase
    endfunction

    // Only a single low row is a valid press; two or more low rows are ghosting.
    always_comb begin
        single_low = 1'b1;
        low_row    = 2'd0;
        case (ls)
            4'b1110: low_row = 2'd0;
            4'b1101: low_row = 2'd1;
            4'b1011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: single_low = 1'b0;
        endcase
    end

    assign row_pat = ~(4'b0001 << row);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= 4'b1111;
            ls            <= 4'b1111;
            state         <= SCAN;
            col           <= 2'd0;
            row           <= 2'd0;
            colunas       <= 4'b1110;
            div_cnt       <= '0;
            deb_cnt       <= '0;
            rel_cnt       <= '0;
            tecla_ativada <= 1'b0;
            digito        <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt       <= '0;
`endif
        end else begin
            sync1         <= linhas;
            ls            <= sync1;
            tecla_ativada <= 1'b0;
            case (state)
                SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (single_low) begin
                            row     <= low_row;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col     <= col + 2'd1;
                            colunas <= col_drive(col + 2'd1);
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (ls != row_pat) begin
                        state   <= SCAN;
                        div_cnt <= '0;
                        col     <= col + 2'd1;
                        colunas <= col_drive(col + 2'd1);
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= PRESSED;
                        tecla_ativada <= 1'b1;
                        digito        <= key_code(row, col);
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    state   <= HELD;
                    rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt <= '0;
`endif
                end
                HELD: begin
                    if (!ls[row]) begin
                        rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_cnt == REP_FIRE) begin
                            state         <= PRESSED;
                            tecla_ativada <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt <= '0;
`endif
                        if (rel_cnt == DEB_LAST) begin
                            state   <= SCAN;
                            div_cnt <= '0;
                            col     <= col + 2'd1;
                            colunas <= col_drive(col + 2'd1);
                        end else begin
                            rel_cnt <= rel_cnt + 1'b1;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset) tecla_ativada |=> !tecla_ativada);
    assert property (@(posedge clk) disable iff (reset) $countones(~colunas) == 1);

endmodule
